// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: request/address from the sequencer, accept from memory.
interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// NanoQuarter program counter and fetch sequencer: PC+2 per accepted fetch,
// bne redirect with a fetch-shadow flush window, and an absorbing halt.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    br_taken,
  input  logic [15:0]             br_pc,
  input  logic [4:0]              br_off,
  input  logic                    halt,
  pc_sequencer_if.master          imem,
  output logic                    if_valid,
  output logic [15:0]             if_pc,
  output logic                    flush,
  output logic                    halted
);

  typedef enum logic [1:0] {StFetch, StFlush, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] br_target;

  assign br_target      = br_pc + {11'b0, br_off};
  assign imem.imem_req  = (state_q == StFetch) & ~stall & ~rst;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = 1'b0;
    flush_d    = 1'b0;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StFetch: begin
        // Branch beats halt and discards any same-cycle ack.
        if (br_taken) begin
          pc_d    = br_target;
          state_d = StFlush;
          flush_d = 1'b1;
          cnt_d   = 3'(FLUSH_CYCLES);
        end else if (halt) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else if (imem.imem_req && imem.imem_ack) begin
          pc_d       = pc_q + 16'd2;
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
        end
      end
      StFlush: begin
        if (br_taken) begin
          pc_d    = br_target;
          flush_d = 1'b1;
          cnt_d   = 3'(FLUSH_CYCLES);
        end else if (cnt_q <= 3'd1) begin
          state_d = StFetch;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      StHalt: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign flush    = flush_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with FLUSH_CYCLES=1, one with 3.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, br_taken, halt, ack;
  logic [15:0] br_pc;
  logic [4:0]  br_off;
  logic        if_valid1, flush1, halted1, if_valid3, flush3, halted3;
  logic [15:0] if_pc1, if_pc3;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if bus1 ();
  pc_sequencer_if bus3 ();
  assign bus1.imem_ack = ack;
  assign bus3.imem_ack = ack;

  pc_sequencer #(.RESET_PC(16'h0000), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_pc(br_pc),
    .br_off(br_off), .halt(halt), .imem(bus1.master), .if_valid(if_valid1),
    .if_pc(if_pc1), .flush(flush1), .halted(halted1)
  );

  pc_sequencer #(.RESET_PC(16'h0000), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_pc(br_pc),
    .br_off(br_off), .halt(halt), .imem(bus3.master), .if_valid(if_valid3),
    .if_pc(if_pc3), .flush(flush3), .halted(halted3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic branch(input logic [15:0] pc, input logic [4:0] off);
    br_taken = 1'b1;
    br_pc    = pc;
    br_off   = off;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; halt = 1'b0; ack = 1'b0;
    br_pc = 16'h0; br_off = 5'd0;
    #1;
    chk("req_in_rst", 32'(bus1.imem_req), 32'h0);
    tick();
    chk("req_in_rst2", 32'(bus1.imem_req), 32'h0);
    tick();
    chk("rst_addr", 32'(bus1.imem_addr), 32'h0000);
    chk("rst_if_valid", 32'(if_valid1), 32'h0);
    chk("rst_if_pc", 32'(if_pc1), 32'h0000);
    chk("rst_flush", 32'(flush1), 32'h0);
    chk("rst_halted", 32'(halted1), 32'h0);

    // 1: streaming fetch
    rst = 1'b0; ack = 1'b1;
    #1;
    chk("t1_req", 32'(bus1.imem_req), 32'h1);
    chk("t1_addr0", 32'(bus1.imem_addr), 32'h0000);
    tick();
    chk("t1_addr1", 32'(bus1.imem_addr), 32'h0002);
    chk("t1_valid1", 32'(if_valid1), 32'h1);
    chk("t1_ifpc1", 32'(if_pc1), 32'h0000);
    tick();
    chk("t1_addr2", 32'(bus1.imem_addr), 32'h0004);
    chk("t1_ifpc2", 32'(if_pc1), 32'h0002);

    // 2: reach 00FE via branch, then branch 00FC+20 with ack present
    branch(16'h00F0, 5'd14);
    tick();
    br_taken = 1'b0;
    chk("t2_addr_fe", 32'(bus1.imem_addr), 32'h00FE);
    chk("t2_flush_a", 32'(flush1), 32'h1);
    chk("t2_valid_a", 32'(if_valid1), 32'h0);
    #1;
    chk("t2_req_flush", 32'(bus1.imem_req), 32'h0);
    tick();
    chk("t2_flush_off", 32'(flush1), 32'h0);
    chk("t2_req_back", 32'(bus1.imem_req), 32'h1);
    branch(16'h00FC, 5'd20);
    tick();
    br_taken = 1'b0;
    chk("t2_target", 32'(bus1.imem_addr), 32'h0110);
    chk("t2_flush_b", 32'(flush1), 32'h1);
    chk("t2_valid_b", 32'(if_valid1), 32'h0);
    tick();
    chk("t2_flush_b_off", 32'(flush1), 32'h0);
    chk("t2_fetch_addr", 32'(bus1.imem_addr), 32'h0110);
    tick();
    chk("t2_valid_c", 32'(if_valid1), 32'h1);
    chk("t2_ifpc_c", 32'(if_pc1), 32'h0110);
    chk("t2_addr_c", 32'(bus1.imem_addr), 32'h0112);

    // 3: PC wrap and branch-target wrap
    branch(16'hFFF0, 5'd14);
    tick();
    br_taken = 1'b0;
    tick();
    chk("t3_addr_fffe", 32'(bus1.imem_addr), 32'hFFFE);
    tick();
    chk("t3_wrap", 32'(bus1.imem_addr), 32'h0000);
    chk("t3_ifpc", 32'(if_pc1), 32'hFFFE);
    branch(16'hFFF0, 5'd31);
    tick();
    br_taken = 1'b0;
    chk("t3_target_wrap", 32'(bus1.imem_addr), 32'h000F);
    tick();

    // 4: stall holds PC; branch during stall still redirects
    tick();
    chk("t4_pre", 32'(bus1.imem_addr), 32'h0011);
    stall = 1'b1;
    #1;
    chk("t4_req_stall", 32'(bus1.imem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_frozen", 32'(bus1.imem_addr), 32'h0011);
      chk("t4_valid0", 32'(if_valid1), 32'h0);
    end
    stall = 1'b0;
    #1;
    chk("t4_resume_req", 32'(bus1.imem_req), 32'h1);
    tick();
    chk("t4_resume", 32'(bus1.imem_addr), 32'h0013);
    stall = 1'b1;
    branch(16'h0200, 5'd0);
    tick();
    br_taken = 1'b0;
    chk("t4_br_stall", 32'(bus1.imem_addr), 32'h0200);
    chk("t4_br_flush", 32'(flush1), 32'h1);
    tick();
    chk("t4_stall_nreq", 32'(bus1.imem_req), 32'h0);
    stall = 1'b0;
    tick();
    chk("t4_after", 32'(bus1.imem_addr), 32'h0202);
    chk("t4_ifpc", 32'(if_pc1), 32'h0200);

    // 5: branch beats halt; halt in FLUSH ignored; then absorbing halt
    halt = 1'b1;
    branch(16'h0300, 5'd2);
    tick();
    br_taken = 1'b0;
    chk("t5_not_halted", 32'(halted1), 32'h0);
    chk("t5_br_addr", 32'(bus1.imem_addr), 32'h0302);
    tick();
    halt = 1'b0;
    chk("t5_flush_halt_ign", 32'(halted1), 32'h0);
    tick();
    chk("t5_adv", 32'(bus1.imem_addr), 32'h0304);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t5_halted", 32'(halted1), 32'h1);
    chk("t5_ack_drop", 32'(bus1.imem_addr), 32'h0304);
    chk("t5_req0", 32'(bus1.imem_req), 32'h0);
    branch(16'h0000, 5'd8);
    tick();
    br_taken = 1'b0;
    chk("t5_br_ignored", 32'(bus1.imem_addr), 32'h0304);
    chk("t5_still_halted", 32'(halted1), 32'h1);
    chk("t5_no_flush", 32'(flush1), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_halted", 32'(halted1), 32'h0);
    chk("t5_rst_pc", 32'(bus1.imem_addr), 32'h0000);
    #1;
    chk("t5_rst_req", 32'(bus1.imem_req), 32'h1);

    // 6: FLUSH_CYCLES=3 with a re-target inside the flush window
    branch(16'h0040, 5'd4);
    tick();
    br_taken = 1'b0;
    chk("t6_flush_a", 32'(flush3), 32'h1);
    chk("t6_addr_a", 32'(bus3.imem_addr), 32'h0044);
    tick();
    chk("t6_flush_b", 32'(flush3), 32'h1);
    branch(16'h0080, 5'd1);
    tick();
    br_taken = 1'b0;
    chk("t6_retarget", 32'(bus3.imem_addr), 32'h0081);
    chk("t6_flush_c1", 32'(flush3), 32'h1);
    chk("t6_req0", 32'(bus3.imem_req), 32'h0);
    tick();
    chk("t6_flush_c2", 32'(flush3), 32'h1);
    tick();
    chk("t6_flush_c3", 32'(flush3), 32'h1);
    chk("t6_req_still0", 32'(bus3.imem_req), 32'h0);
    tick();
    chk("t6_flush_end", 32'(flush3), 32'h0);
    chk("t6_fetch_addr", 32'(bus3.imem_addr), 32'h0081);
    chk("t6_fetch_req", 32'(bus3.imem_req), 32'h1);

    // reset in the middle of a flush window
    branch(16'h0100, 5'd0);
    tick();
    br_taken = 1'b0;
    chk("t6_flush_pre_rst", 32'(flush3), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_flush", 32'(flush3), 32'h0);
    chk("t6_rst_addr", 32'(bus3.imem_addr), 32'h0000);
    #1;
    chk("t6_rst_req", 32'(bus3.imem_req), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
